coh_ctrl_rr: RTL and testbench

- N-CPU successor of the two-CPU coherence controller and RAM arbiter.
- Sits between CPUS L1 I/D cache pairs and the single RAM port.
- Serialises coherence transactions (BusRd/BusRdX) with round-robin fairness and broadcasts snoops to every other cache.
- Sources data cache-to-cache when a snooper holds the line dirty, otherwise from RAM. Arbitrates plain writebacks and instruction fetches, each class with its own round-robin pointer.

---
 rtl/coh_ctrl_rr.sv | 203 ++++++++++++++++++++
 tb/tb_coh_ctrl_rr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/coh_ctrl_rr.sv
// N-CPU coherence controller and RAM arbiter: round-robin BusRd/BusRdX serialisation, writebacks and ifetches.
// Optional statistics counters are enabled with `define COH_STATS_EN.
module coh_ctrl_rr #(
    parameter int CPUS      = 2,
    parameter int SNOOP_LAT = 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS-1:0][31:0]  ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore
`ifdef COH_STATS_EN
    ,
    output logic [31:0]            stat_snoops,
    output logic [31:0]            stat_c2c,
    output logic [31:0]            stat_ramrd
`endif
);
    // state    | meaning
    // IDLE     | arbitrate coherence > writeback > ifetch
    // SNOOP    | snoopers frozen, waiting SNOOP_LAT cycles for ccwrite
    // C2C      | dirty snooper supplies the line, RAM updated in parallel
    // RAM_XFER | requester served from / to RAM
    typedef enum logic [1:0] {IDLE, SNOOP, C2C, RAM_XFER} state_t;

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CW = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT + 1) : 1;
    localparam logic [1:0] ACCESS = 2'b10;

    state_t          state, state_n;
    logic [IW-1:0]   req, req_n, sup, sup_n;
    logic [IW-1:0]   coh_ptr, coh_ptr_n, wb_ptr, wb_ptr_n, if_ptr, if_ptr_n;
    logic [IW-1:0]   coh_g, wb_g, if_g, sup_sel;
    logic [CW-1:0]   snoop_cnt, snoop_cnt_n;
    logic            has_sup;

    // First requester strictly after the pointer; descending scan lets the nearest one win.
    function automatic logic [IW-1:0] rr(input logic [CPUS-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] g;
        g = p;
        for (int i = CPUS; i >= 1; i--) begin
            if (r[(int'(p) + i) % CPUS]) g = IW'((int'(p) + i) % CPUS);
        end
        return g;
    endfunction

    assign coh_g = rr(cctrans, coh_ptr);
    assign wb_g  = rr(dWEN, wb_ptr);
    assign if_g  = rr(iREN, if_ptr);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            req       <= '0;
            sup       <= '0;
            coh_ptr   <= IW'(CPUS - 1);
            wb_ptr    <= IW'(CPUS - 1);
            if_ptr    <= IW'(CPUS - 1);
            snoop_cnt <= '0;
        end else begin
            state     <= state_n;
            req       <= req_n;
            sup       <= sup_n;
            coh_ptr   <= coh_ptr_n;
            wb_ptr    <= wb_ptr_n;
            if_ptr    <= if_ptr_n;
            snoop_cnt <= snoop_cnt_n;
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        state_n     = state;
        req_n       = req;
        sup_n       = sup;
        coh_ptr_n   = coh_ptr;
        wb_ptr_n    = wb_ptr;
        if_ptr_n    = if_ptr;
        snoop_cnt_n = snoop_cnt;
        has_sup     = 1'b0;
        sup_sel     = '0;

        if (state != IDLE) begin
            for (int k = 0; k < CPUS; k++) begin
                if (k != int'(req)) begin
                    ccsnoopaddr[k] = daddr[req];
                    ccwait[k]      = 1'b1;
                    ccinv[k]       = ccwrite[req];
                end
            end
        end

        case (state)
            IDLE: begin
                if (|cctrans) begin
                    req_n         = coh_g;
                    coh_ptr_n     = coh_g;
                    ccwait        = '1;
                    ccwait[coh_g] = 1'b0;
                    snoop_cnt_n   = '0;
                    state_n       = SNOOP;
                end else if (|dWEN) begin
                    ramWEN       = 1'b1;
                    ramaddr      = daddr[wb_g];
                    ramstore     = dstore[wb_g];
                    dwait[wb_g]  = (ramstate != ACCESS);
                    if (ramstate == ACCESS) wb_ptr_n = wb_g;
                end else if (|iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[if_g];
                    if (ramstate == ACCESS) begin
                        iwait[if_g] = 1'b0;
                        iload[if_g] = ramload;
                        if_ptr_n    = if_g;
                    end
                end
            end
            SNOOP: begin
                snoop_cnt_n = snoop_cnt + CW'(1);
                if (!cctrans[req]) begin
                    state_n = IDLE;
                end else if (snoop_cnt == CW'(SNOOP_LAT - 1)) begin
                    for (int k = CPUS - 1; k >= 0; k--) begin
                        if (k != int'(req) && ccwrite[k]) begin
                            has_sup = 1'b1;
                            sup_sel = IW'(k);
                        end
                    end
                    if (has_sup) begin
                        sup_n   = sup_sel;
                        state_n = C2C;
                    end else begin
                        state_n = RAM_XFER;
                    end
                end
            end
            C2C: begin
                dload[req] = dstore[sup];
                ramWEN     = 1'b1;
                ramaddr    = daddr[req];
                ramstore   = dstore[sup];
                dwait[req] = (ramstate != ACCESS);
                dwait[sup] = (ramstate != ACCESS);
                if (!cctrans[req]) state_n = IDLE;
            end
            RAM_XFER: begin
                ramREN     = dREN[req];
                ramWEN     = dWEN[req];
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dload[req] = ramload;
                dwait[req] = (ramstate != ACCESS);
                if (!cctrans[req]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (ramWEN) ramREN = 1'b0;
    end

`ifdef COH_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_snoops <= '0;
            stat_c2c    <= '0;
            stat_ramrd  <= '0;
        end else begin
            if (state == IDLE && state_n == SNOOP)      stat_snoops <= stat_snoops + 32'd1;
            if (state == SNOOP && state_n == C2C)       stat_c2c    <= stat_c2c + 32'd1;
            if (state == SNOOP && state_n == RAM_XFER)  stat_ramrd  <= stat_ramrd + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coh_ctrl_rr.sv
// Directed bench for coh_ctrl_rr (CPUS=4) with a second SNOOP_LAT=3 instance sharing the inputs.
module tb_coh_ctrl_rr;
    logic              CLK = 1'b0;
    logic              nRST;
    logic [3:0]        iREN, dREN, dWEN, cctrans, ccwrite;
    logic [3:0][31:0]  iaddr, daddr, dstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;

    logic [3:0]        iwait, dwait, ccwait, ccinv;
    logic [3:0][31:0]  iload, dload, ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore;

    logic [3:0]        l_iwait, l_dwait, l_ccwait, l_ccinv;
    logic [3:0][31:0]  l_iload, l_dload, l_ccsnoopaddr;
    logic              l_ramREN, l_ramWEN;
    logic [31:0]       l_ramaddr, l_ramstore;
`ifdef COH_STATS_EN
    logic [31:0]       s_snoops, s_c2c, s_ramrd, ls_snoops, ls_c2c, ls_ramrd;
`endif

    int vecs = 0;
    int miss = 0;

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10;

    always #5 CLK = ~CLK;

    coh_ctrl_rr #(.CPUS(4), .SNOOP_LAT(1)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
        .ramload(ramload), .ramstate(ramstate), .iwait(iwait), .iload(iload),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore)
`ifdef COH_STATS_EN
        , .stat_snoops(s_snoops), .stat_c2c(s_c2c), .stat_ramrd(s_ramrd)
`endif
    );

    coh_ctrl_rr #(.CPUS(4), .SNOOP_LAT(3)) u_lat3 (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
        .ramload(ramload), .ramstate(ramstate), .iwait(l_iwait), .iload(l_iload),
        .dwait(l_dwait), .dload(l_dload), .ccwait(l_ccwait), .ccinv(l_ccinv),
        .ccsnoopaddr(l_ccsnoopaddr), .ramREN(l_ramREN), .ramWEN(l_ramWEN),
        .ramaddr(l_ramaddr), .ramstore(l_ramstore)
`ifdef COH_STATS_EN
        , .stat_snoops(ls_snoops), .stat_c2c(ls_c2c), .stat_ramrd(ls_ramrd)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    initial begin
        int order[3];
        order = '{3, 1, 3};
        clear_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        #1;
        chk("rst_iwait", 32'(iwait), 32'hF);
        chk("rst_dwait", 32'(dwait), 32'hF);
        chk("rst_ccwait", 32'(ccwait), 32'h0);
        chk("rst_ram", {30'd0, ramREN, ramWEN}, 32'h0);

        // CPU1 and CPU3 contend; CPU1 wins and is served from RAM
        daddr[1] = 32'h40; daddr[3] = 32'h80;
        cctrans = 4'b1010;
        #1;
        chk("grant1_ccwait", 32'(ccwait), 32'hD);
        tick();
        chk("snoop_addr0", ccsnoopaddr[0], 32'h40);
        chk("snoop_ccinv", 32'(ccinv), 32'h0);
        chk("snoop_ccwait", 32'(ccwait), 32'hD);
        tick();
        dREN[1] = 1'b1; ramstate = ACCESS; ramload = 32'h12345678;
        #1;
        chk("xfer_ramREN", 32'(ramREN), 32'h1);
        chk("xfer_dload1", dload[1], 32'h12345678);
        chk("xfer_dwait", 32'(dwait), 32'hD);
        chk("xfer_ramaddr", ramaddr, 32'h40);
        cctrans = 4'b1000;
        #1;
        tick();
        dREN = '0;
        cctrans = 4'b1010;
        #1;
        chk("idle_after_xfer_ramREN", 32'(ramREN), 32'h0);
        chk("grant3_ccwait", 32'(ccwait), 32'h7);

        for (int i = 0; i < 3; i++) begin
            cctrans = 4'b1010;
            #1;
            chk("rr_order_ccwait", 32'(ccwait), 32'(~(4'b0001 << order[i]) & 4'hF));
            tick();
            tick();
            cctrans = 4'b1010 & ~(4'b0001 << order[i]);
            #1;
            tick();
        end
        cctrans = '0;
        ramstate = FREE;
        tick();

        // CPU0 BusRdX, CPU2 supplies dirty data
        daddr[0] = 32'h100; dstore[0] = 32'h0BAD0000; dstore[2] = 32'hDEADBEEF;
        ccwrite = 4'b0101;
        cctrans = 4'b0001;
        #1;
        chk("c2c_grant_ccwait", 32'(ccwait), 32'hE);
        tick();
        chk("c2c_snoop_ccinv", 32'(ccinv), 32'hE);
        chk("c2c_snoop_addr2", ccsnoopaddr[2], 32'h100);
        tick();
        chk("c2c_dload0", dload[0], 32'hDEADBEEF);
        chk("c2c_ramWEN", 32'(ramWEN), 32'h1);
        chk("c2c_ramaddr", ramaddr, 32'h100);
        chk("c2c_ramstore", ramstore, 32'hDEADBEEF);
        chk("c2c_dwait_free", 32'(dwait), 32'hF);
        ramstate = BUSY;
        tick();
        chk("c2c_dwait_busy1", 32'(dwait), 32'hF);
        tick();
        chk("c2c_dwait_busy2", 32'(dwait), 32'hF);
        ramstate = ACCESS;
        #1;
        chk("c2c_dwait_access", 32'(dwait), 32'hA);
        chk("c2c_ccinv_hold", 32'(ccinv), 32'hE);

        // reset while still in C2C
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        clear_inputs();
        #1;
        chk("rst_c2c_ramWEN", 32'(ramWEN), 32'h0);
        chk("rst_c2c_dwait", 32'(dwait), 32'hF);
        chk("rst_c2c_ccwait", 32'(ccwait), 32'h0);
        chk("rst_c2c_dload0", dload[0], 32'h0);
        cctrans = 4'b1111;
        #1;
        chk("rst_c2c_cpu0_wins", 32'(ccwait), 32'hE);
        cctrans = '0;
        #1;

        // writeback before ifetch, then fetches rotate 0..3
        dWEN = 4'b0001; iREN = 4'b1111;
        daddr[0] = 32'h200; dstore[0] = 32'hCAFE0001;
        for (int i = 0; i < 4; i++) iaddr[i] = 32'h1000 + 32'(4 * i);
        ramstate = ACCESS;
        #1;
        chk("wb_ramWEN", 32'(ramWEN), 32'h1);
        chk("wb_ramREN", 32'(ramREN), 32'h0);
        chk("wb_ramaddr", ramaddr, 32'h200);
        chk("wb_ramstore", ramstore, 32'hCAFE0001);
        chk("wb_dwait", 32'(dwait), 32'hE);
        chk("wb_iwait", 32'(iwait), 32'hF);
        tick();
        dWEN = '0;
        ramstate = BUSY;
        #1;
        chk("if_busy_iwait", 32'(iwait), 32'hF);
        chk("if_busy_ramREN", 32'(ramREN), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ramstate = ACCESS;
            ramload = 32'hA0 + 32'(i);
            #1;
            chk("if_iwait", 32'(iwait), 32'(~(4'b0001 << i) & 4'hF));
            chk("if_ramaddr", ramaddr, 32'h1000 + 32'(4 * i));
            chk("if_iload", iload[i], 32'hA0 + 32'(i));
            tick();
        end
        clear_inputs();

        // SNOOP_LAT=3 instance: requester abandons during second SNOOP cycle
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ramstate = ACCESS;
        dREN = 4'b0100;
        daddr[2] = 32'h300;
        cctrans = 4'b0100;
        #1;
        chk("lat3_grant", 32'(l_ccwait), 32'hB);
        tick();
        chk("lat3_snoop1_ram", {30'd0, l_ramREN, l_ramWEN}, 32'h0);
        chk("lat3_snoop1_addr", l_ccsnoopaddr[0], 32'h300);
        tick();
        chk("lat3_snoop2_ram", {30'd0, l_ramREN, l_ramWEN}, 32'h0);
        chk("lat3_snoop2_ccwait", 32'(l_ccwait), 32'hB);
        cctrans = '0;
        #1;
        chk("lat3_drop_ram", {30'd0, l_ramREN, l_ramWEN}, 32'h0);
        tick();
        chk("lat3_idle_ccwait", 32'(l_ccwait), 32'h0);
        chk("lat3_idle_ram", {30'd0, l_ramREN, l_ramWEN}, 32'h0);
        tick();
        chk("lat3_idle2_ram", {30'd0, l_ramREN, l_ramWEN}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
